nonogram_line_deducer: RTL and testbench

//  Next-generation line solver for the nonogram engine; generalises the fixed-size FIFO solver to a rectangular ROWS x COLS board.

---
 rtl/nonogram_line_deducer.sv | 198 +++++++++++++++++++
 tb/tb_nonogram_line_deducer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_line_deducer.sv
// nonogram_line_deducer: single-line deduction engine for a ROWS x COLS nonogram.
// A header beat opens a line and is followed by that line's candidate fills.
// Candidates that disagree with the board are discarded. The survivors are ANDed
// to find cells forced to 1 or to 0, those cells are committed, and one result
// is reported per line.
// Optional macro NONOGRAM_FILTER_OUT_EN adds a survivor stream (fo_valid/fo_ready/fo_data)
// that re-emits each surviving option unchanged, in arrival order.
module nonogram_line_deducer #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int MAX_LEN = (ROWS > COLS) ? ROWS : COLS,
  parameter int CNT_W   = 10,
  parameter int IDX_W   = $clog2(ROWS + COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_hdr,
  input  logic [MAX_LEN-1:0]   in_data,
  input  logic [CNT_W-1:0]     in_count,
  output logic [ROWS*COLS-1:0] known,
  output logic [ROWS*COLS-1:0] assigned,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_W-1:0]     res_line,
  output logic [CNT_W-1:0]     res_valid_cnt,
  output logic [MAX_LEN-1:0]   res_new_known,
  output logic                 res_requeue,
  output logic                 res_contra,
`ifdef NONOGRAM_FILTER_OUT_EN
  output logic                 fo_valid,
  input  logic                 fo_ready,
  output logic [MAX_LEN-1:0]   fo_data,
`endif
  output logic                 res_err
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REPORT} state_t;

  state_t               state;
  logic [IDX_W-1:0]     line_idx;
  logic [CNT_W-1:0]     remaining, total, valid_cnt;
  logic [MAX_LEN-1:0]   and1, and0;
  logic [MAX_LEN-1:0]   len_mask, line_known, line_assigned, new_known;
  logic [ROWS*COLS-1:0] known_nxt, assigned_nxt;
  int                   cell_idx [MAX_LEN];
  logic                 fo_stall, fo_pending, accept, hdr_ok, opt_ok, requeue_nxt;

`ifdef NONOGRAM_FILTER_OUT_EN
  assign fo_stall   = fo_valid & ~fo_ready;
  assign fo_pending = fo_valid;
`else
  assign fo_stall   = 1'b0;
  assign fo_pending = 1'b0;
`endif

  assign in_ready = !rst && (state == IDLE || (state == CHECK && !fo_stall));
  assign accept   = in_valid && in_ready;
  assign hdr_ok   = int'(in_data[IDX_W-1:0]) < ROWS + COLS;
  assign opt_ok   = ((in_data ^ line_assigned) & line_known & len_mask) == '0;

  // Map line positions to board cells. Rows run along c, columns run along r.
  always_comb begin
    int row, col;
    len_mask      = '0;
    line_known    = '0;
    line_assigned = '0;
    row = int'(line_idx);
    col = row - ROWS;
    for (int j = 0; j < MAX_LEN; j++) begin
      cell_idx[j] = 0;
      if (row < ROWS) begin
        if (j < COLS) begin
          cell_idx[j] = row * COLS + j;
          len_mask[j] = 1'b1;
        end
      end else if (row < ROWS + COLS && j < ROWS) begin
        cell_idx[j] = j * COLS + col;
        len_mask[j] = 1'b1;
      end
      line_known[j]    = len_mask[j] & known[cell_idx[j]];
      line_assigned[j] = len_mask[j] & assigned[cell_idx[j]];
    end
  end

  // Compute the board after forced cells are committed. No survivors means nothing is forced.
  always_comb begin
    known_nxt    = known;
    assigned_nxt = assigned;
    new_known    = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (valid_cnt != '0 && len_mask[j] && (and1[j] || and0[j])) begin
        new_known[j]              = ~known[cell_idx[j]];
        known_nxt[cell_idx[j]]    = 1'b1;
        assigned_nxt[cell_idx[j]] = and1[j];
      end
    end
    requeue_nxt = (valid_cnt >= CNT_W'(2)) && (new_known != '0 || valid_cnt < total);
  end

  // Line FSM. Results and board updates are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      line_idx      <= '0;
      remaining     <= '0;
      total         <= '0;
      valid_cnt     <= '0;
      and1          <= '1;
      and0          <= '1;
      known         <= '0;
      assigned      <= '0;
      res_valid     <= 1'b0;
      res_line      <= '0;
      res_valid_cnt <= '0;
      res_new_known <= '0;
      res_requeue   <= 1'b0;
      res_contra    <= 1'b0;
      res_err       <= 1'b0;
`ifdef NONOGRAM_FILTER_OUT_EN
      fo_valid      <= 1'b0;
      fo_data       <= '0;
`endif
    end else begin
`ifdef NONOGRAM_FILTER_OUT_EN
      if (fo_valid && fo_ready) fo_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (accept && in_is_hdr) begin
          line_idx  <= in_data[IDX_W-1:0];
          remaining <= in_count;
          total     <= in_count;
          valid_cnt <= '0;
          and1      <= '1;
          and0      <= '1;
          if (!hdr_ok) begin
            state         <= REPORT;
            res_valid     <= 1'b1;
            res_line      <= in_data[IDX_W-1:0];
            res_valid_cnt <= '0;
            res_new_known <= '0;
            res_requeue   <= 1'b0;
            res_contra    <= 1'b0;
            res_err       <= 1'b1;
          end else if (in_count == '0) begin
            state <= COMMIT;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: if (accept) begin
          if (in_is_hdr) begin
            // A header arriving mid-line aborts the line. The header itself is swallowed.
            state         <= REPORT;
            res_valid     <= 1'b1;
            res_line      <= line_idx;
            res_valid_cnt <= '0;
            res_new_known <= '0;
            res_requeue   <= 1'b0;
            res_contra    <= 1'b0;
            res_err       <= 1'b1;
          end else begin
            if (opt_ok) begin
              if (valid_cnt != '1) valid_cnt <= valid_cnt + CNT_W'(1);
              and1 <= and1 & in_data;
              and0 <= and0 & ~in_data;
`ifdef NONOGRAM_FILTER_OUT_EN
              fo_valid <= 1'b1;
              fo_data  <= in_data;
`endif
            end
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= COMMIT;
          end
        end
        COMMIT: if (!fo_pending) begin
          known         <= known_nxt;
          assigned      <= assigned_nxt;
          state         <= REPORT;
          res_valid     <= 1'b1;
          res_line      <= line_idx;
          res_valid_cnt <= valid_cnt;
          res_new_known <= new_known;
          res_requeue   <= requeue_nxt;
          res_contra    <= (valid_cnt == '0);
          res_err       <= 1'b0;
        end
        REPORT: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonogram_line_deducer.sv
// Directed bench for nonogram_line_deducer on a 3x4 board.
// A reference board model predicts each line result and pushes it to a queue.
// Results are popped from the queue and compared when the DUT reports.
module tb_nonogram_line_deducer;
  localparam int ROWS = 3, COLS = 4, MAX_LEN = 4, CNT_W = 10, IDX_W = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0, in_is_hdr = 1'b0, res_ready = 1'b0;
  logic [MAX_LEN-1:0]   in_data = '0;
  logic [CNT_W-1:0]     in_count = '0;
  logic                 in_ready, res_valid, res_requeue, res_contra, res_err;
  logic [ROWS*COLS-1:0] known, assigned;
  logic [IDX_W-1:0]     res_line;
  logic [CNT_W-1:0]     res_valid_cnt;
  logic [MAX_LEN-1:0]   res_new_known;

  typedef struct packed {
    logic [IDX_W-1:0]   line;
    logic [CNT_W-1:0]   vcnt;
    logic [MAX_LEN-1:0] nk;
    logic               rq, contra, err;
  } res_t;

  res_t                 exp_q[$];
  logic [ROWS*COLS-1:0] mk = '0, ma = '0;
  logic [MAX_LEN-1:0]   opts [8];
  int                   errors = 0, checks = 0;

  nonogram_line_deducer #(.ROWS(ROWS), .COLS(COLS), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_is_hdr(in_is_hdr),
    .in_data(in_data), .in_count(in_count), .known(known), .assigned(assigned),
    .res_valid(res_valid), .res_ready(res_ready), .res_line(res_line),
    .res_valid_cnt(res_valid_cnt), .res_new_known(res_new_known), .res_requeue(res_requeue),
    .res_contra(res_contra), .res_err(res_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cellof(input int idx, input int j);
    return (idx < ROWS) ? idx * COLS + j : j * COLS + (idx - ROWS);
  endfunction

  // Reference model: filter opts[0..cnt-1] against mk/ma, update the board, and queue the expected result.
  task automatic model_line(input int idx, input int cnt);
    int len, vc, c;
    logic [MAX_LEN-1:0] a1, a0, nk;
    logic bad;
    res_t r;
    len = (idx < ROWS) ? COLS : ROWS;
    vc = 0; a1 = '1; a0 = '1; nk = '0;
    for (int k = 0; k < cnt; k++) begin
      bad = 1'b0;
      for (int j = 0; j < len; j++) begin
        c = cellof(idx, j);
        if (mk[c] && ma[c] != opts[k][j]) bad = 1'b1;
      end
      if (!bad) begin vc++; a1 &= opts[k]; a0 &= ~opts[k]; end
    end
    if (vc > 0)
      for (int j = 0; j < len; j++)
        if (a1[j] || a0[j]) begin
          c = cellof(idx, j);
          if (!mk[c]) nk[j] = 1'b1;
          mk[c] = 1'b1;
          ma[c] = a1[j];
        end
    r.line = IDX_W'(idx); r.vcnt = CNT_W'(vc); r.nk = nk; r.err = 1'b0;
    r.contra = (vc == 0);
    r.rq = (vc >= 2) && (nk != '0 || vc < cnt);
    exp_q.push_back(r);
  endtask

  task automatic send(input string tag, input logic hdr, input logic [MAX_LEN-1:0] d, input int cnt);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_is_hdr = hdr; in_data = d; in_count = CNT_W'(cnt);
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int stall);
    res_t e;
    int n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_stall_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_stall_line"}, 64'(res_line), 64'(e.line));
      chk({tag, "_stall_nk"}, 64'(res_new_known), 64'(e.nk));
      @(negedge clk);
    end
    chk({tag, "_line"}, 64'(res_line), 64'(e.line));
    chk({tag, "_vcnt"}, 64'(res_valid_cnt), 64'(e.vcnt));
    chk({tag, "_new_known"}, 64'(res_new_known), 64'(e.nk));
    chk({tag, "_requeue"}, 64'(res_requeue), 64'(e.rq));
    chk({tag, "_contra"}, 64'(res_contra), 64'(e.contra));
    chk({tag, "_err"}, 64'(res_err), 64'(e.err));
    chk({tag, "_known"}, 64'(known), 64'(mk));
    chk({tag, "_assigned"}, 64'(assigned), 64'(ma));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_res_drop"}, 64'(res_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_line(input string tag, input int idx, input int cnt, input int stall);
    model_line(idx, cnt);
    send({tag, "_hdr"}, 1'b1, MAX_LEN'(idx), cnt);
    for (int k = 0; k < cnt; k++) send({tag, "_opt"}, 1'b0, opts[k], 0);
    get_result(tag, stall);
  endtask

  task automatic push_err(input int idx);
    res_t r;
    r = '0; r.line = IDX_W'(idx); r.err = 1'b1;
    exp_q.push_back(r);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_known", 64'(known), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // An option beat while idle is dropped
    send("idle_opt", 1'b0, 4'b1111, 0);
    repeat (3) @(negedge clk);
    chk("idle_opt_no_res", 64'(res_valid), 64'd0);
    chk("idle_opt_board", 64'(known), 64'd0);

    // Column 1, two options on an empty board: only cell (1,1) is forced
    opts[0] = 4'b0011; opts[1] = 4'b0110;
    run_line("col1", 4, 2, 0);
    chk("col1_known_const", 64'(known), 64'h020);

    // Row 0, a single option fixes the whole row
    opts[0] = 4'b1011;
    run_line("row0", 0, 1, 0);
    chk("row0_known_const", 64'(known), 64'h02F);
    chk("row0_assigned_const", 64'(assigned), 64'h02B);

    // Column 2: option 001 contradicts (0,2)=0, option 000 survives
    opts[0] = 4'b0000; opts[1] = 4'b0001;
    run_line("col2", 5, 2, 0);
    chk("col2_known_const", 64'(known), 64'h46F);

    // Row 0 again, both options contradict -> contradiction
    opts[0] = 4'b0000; opts[1] = 4'b0100;
    run_line("row0_contra", 0, 2, 0);

    // Row 1: two of three survive with nothing new -> requeue on count shrink
    opts[0] = 4'b0011; opts[1] = 4'b1010; opts[2] = 4'b0000;
    run_line("row1_shrink", 1, 3, 0);

    // A header arriving mid-line aborts the line
    push_err(1);
    send("abort_hdr", 1'b1, 4'd1, 3);
    send("abort_opt", 1'b0, 4'b0011, 0);
    send("abort_hdr2", 1'b1, 4'd2, 1);
    get_result("abort", 0);

    // Next line runs normally, with the result held for 5 cycles
    opts[0] = 4'b0001;
    run_line("row2_stall", 2, 1, 5);

    // Out-of-range line index
    push_err(7);
    send("bad_idx_hdr", 1'b1, 4'd7, 1);
    get_result("bad_idx", 0);

    // Zero-option header -> contradiction
    run_line("col0_zero", 3, 0, 0);

    // Reset in the middle of CHECK discards the line
    send("rst_mid_hdr", 1'b1, 4'd6, 2);
    send("rst_mid_opt", 1'b0, 4'b0001, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rst_mid_known", 64'(known), 64'd0);
    chk("rst_mid_assigned", 64'(assigned), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mk = '0; ma = '0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_res", 64'(res_valid), 64'd0);
    chk("rst_mid_idle_ready", 64'(in_ready), 64'd1);

    // The engine works after a mid-line reset
    opts[0] = 4'b1011;
    run_line("row0_after_rst", 0, 1, 0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
